// File: rtl/rv_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and
// the default MDU watchdog limit.
package rv_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PCTL_RUN = 2'd0,
        PCTL_MDU = 2'd1,
        PCTL_MEM = 2'd2
    } pctl_state_t;

    localparam int MDU_MAX_CYC_DEF = 40;

endpackage

// File: rtl/rv_perf_cnt.sv
// Wrapping event counter with enable; used for stall and flush statistics.
module rv_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rstn)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline: merges
// load-use, redirect, MDU and data-memory wait causes into stage controls.
module rv_pipe_ctrl
    import rv_pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MDU_MAX_CYC = MDU_MAX_CYC_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             EX_mem_read_i,
    input  logic [4:0]       EX_reg_rd_i,
    input  logic [4:0]       ID_reg_rs1_i,
    input  logic [4:0]       ID_reg_rs2_i,
    input  logic             EX_redirect_i,
    input  logic             EX_mdu_start_i,
    input  logic             mdu_done_i,
    input  logic             MEM_req_i,
    input  logic             dmem_ready_i,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             ID_EX_write_o,
    output logic             EX_MEM_write_o,
    output logic             MEM_WB_write_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             EX_MEM_flush_o,
    output logic             mdu_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WD_W = $clog2(MDU_MAX_CYC + 1);

    pctl_state_t     state, state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            mdu_pend;
    logic            lu, mem_stall, mdu_stall, wd_expired;

    // x0 is hardwired zero, so a load targeting it can never create a dependency
    assign lu = EX_mem_read_i && (EX_reg_rd_i != 5'd0) &&
                ((EX_reg_rd_i == ID_reg_rs1_i) || (EX_reg_rd_i == ID_reg_rs2_i));
    assign mem_stall  = MEM_req_i && !dmem_ready_i;
    assign mdu_stall  = EX_mdu_start_i && !mdu_done_i;
    assign wd_expired = (state == PCTL_MDU) && !mem_stall && !mdu_done_i &&
                        (wd_cnt == WD_W'(MDU_MAX_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= PCTL_RUN;
        else
            state <= state_nxt;
    end

    // Watchdog only advances in genuine MDU_WAIT cycles; a memory freeze holds it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wd_cnt    <= '0;
            mdu_pend  <= 1'b0;
            mdu_err_o <= 1'b0;
        end else begin
            case (state)
                PCTL_RUN: begin
                    mdu_pend <= 1'b0;
                    if (!mem_stall && mdu_stall)
                        wd_cnt <= '0;
                end
                PCTL_MDU: begin
                    if (mem_stall)
                        mdu_pend <= !mdu_done_i;
                    else if (!mdu_done_i)
                        wd_cnt <= wd_cnt + WD_W'(1);
                    if (wd_expired)
                        mdu_err_o <= 1'b1;
                end
                PCTL_MEM: begin
                    if (mdu_done_i || dmem_ready_i)
                        mdu_pend <= 1'b0;
                end
                default: mdu_pend <= 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PCTL_RUN: begin
                if (mem_stall)
                    state_nxt = PCTL_MEM;
                else if (mdu_stall)
                    state_nxt = PCTL_MDU;
            end
            PCTL_MDU: begin
                if (mem_stall)
                    state_nxt = PCTL_MEM;
                else if (mdu_done_i || wd_expired)
                    state_nxt = PCTL_RUN;
            end
            PCTL_MEM: begin
                if (dmem_ready_i)
                    state_nxt = (mdu_pend && !mdu_done_i) ? PCTL_MDU : PCTL_RUN;
            end
            default: state_nxt = PCTL_RUN;
        endcase
    end

    // A still-pending MDU op keeps its freeze pattern even on the memory-ready cycle
    always_comb begin
        PC_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        ID_EX_write_o  = 1'b1;
        EX_MEM_write_o = 1'b1;
        MEM_WB_write_o = 1'b1;
        IF_ID_flush_o  = 1'b0;
        ID_EX_flush_o  = 1'b0;
        EX_MEM_flush_o = 1'b0;
        if (rstn) begin
            case (state)
                PCTL_RUN: begin
                    if (mem_stall) begin
                        {PC_write_o, IF_ID_write_o, ID_EX_write_o,
                         EX_MEM_write_o, MEM_WB_write_o} = 5'b00000;
                    end else if (mdu_stall) begin
                        {PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o} = 4'b0000;
                        EX_MEM_flush_o = 1'b1;
                    end else if (EX_redirect_i) begin
                        IF_ID_flush_o = 1'b1;
                        ID_EX_flush_o = 1'b1;
                    end else if (lu) begin
                        PC_write_o    = 1'b0;
                        IF_ID_write_o = 1'b0;
                        ID_EX_flush_o = 1'b1;
                    end
                end
                PCTL_MDU: begin
                    if (mem_stall) begin
                        {PC_write_o, IF_ID_write_o, ID_EX_write_o,
                         EX_MEM_write_o, MEM_WB_write_o} = 5'b00000;
                    end else if (!mdu_done_i && !wd_expired) begin
                        {PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o} = 4'b0000;
                        EX_MEM_flush_o = 1'b1;
                    end
                end
                PCTL_MEM: begin
                    if (!dmem_ready_i) begin
                        {PC_write_o, IF_ID_write_o, ID_EX_write_o,
                         EX_MEM_write_o, MEM_WB_write_o} = 5'b00000;
                    end else if (mdu_pend && !mdu_done_i) begin
                        {PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o} = 4'b0000;
                        EX_MEM_flush_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    rv_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (!PC_write_o),
        .cnt  (stall_cnt_o)
    );

    rv_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (IF_ID_flush_o),
        .cnt  (flush_cnt_o)
    );

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Directed self-checking bench for rv_pipe_ctrl: hazards, redirects, MDU
// sequencing, watchdog, nested memory wait and mid-wait reset.
module tb_rv_pipe_ctrl;

    localparam int CNT_W = 32;

    localparam logic [7:0] CTL_RUN = 8'b11111_000;
    localparam logic [7:0] CTL_LU  = 8'b00111_010;
    localparam logic [7:0] CTL_RED = 8'b11111_110;
    localparam logic [7:0] CTL_MDU = 8'b00001_001;
    localparam logic [7:0] CTL_MEM = 8'b00000_000;

    logic             clk = 1'b0;
    logic             rstn;
    logic             EX_mem_read_i, EX_redirect_i, EX_mdu_start_i, mdu_done_i;
    logic             MEM_req_i, dmem_ready_i;
    logic [4:0]       EX_reg_rd_i, ID_reg_rs1_i, ID_reg_rs2_i;
    logic             PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o;
    logic             IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o, mdu_err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic [7:0]       ctl;

    int n_cmp = 0;
    int n_err = 0;

    rv_pipe_ctrl #(.CNT_W(CNT_W), .MDU_MAX_CYC(40)) dut (
        .clk(clk), .rstn(rstn),
        .EX_mem_read_i(EX_mem_read_i), .EX_reg_rd_i(EX_reg_rd_i),
        .ID_reg_rs1_i(ID_reg_rs1_i), .ID_reg_rs2_i(ID_reg_rs2_i),
        .EX_redirect_i(EX_redirect_i), .EX_mdu_start_i(EX_mdu_start_i),
        .mdu_done_i(mdu_done_i), .MEM_req_i(MEM_req_i), .dmem_ready_i(dmem_ready_i),
        .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o),
        .ID_EX_write_o(ID_EX_write_o), .EX_MEM_write_o(EX_MEM_write_o),
        .MEM_WB_write_o(MEM_WB_write_o), .IF_ID_flush_o(IF_ID_flush_o),
        .ID_EX_flush_o(ID_EX_flush_o), .EX_MEM_flush_o(EX_MEM_flush_o),
        .mdu_err_o(mdu_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    assign ctl = {PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o,
                  IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        EX_mem_read_i  = 1'b0;
        EX_reg_rd_i    = 5'd0;
        ID_reg_rs1_i   = 5'd0;
        ID_reg_rs2_i   = 5'd0;
        EX_redirect_i  = 1'b0;
        EX_mdu_start_i = 1'b0;
        mdu_done_i     = 1'b0;
        MEM_req_i      = 1'b0;
        dmem_ready_i   = 1'b1;
    endtask

    // Advance one edge; inputs change and outputs settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int stalls;

    initial begin
        clr();
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_ctl", 32'(ctl), 32'(CTL_RUN));
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_flush", flush_cnt_o, 0);
        chk("rst_err", 32'(mdu_err_o), 0);
        rstn = 1'b1;
        #1;
        chk("idle_ctl", 32'(ctl), 32'(CTL_RUN));

        // load-use on rs1
        EX_mem_read_i = 1'b1; EX_reg_rd_i = 5'd5; ID_reg_rs1_i = 5'd5; #1;
        chk("lu_rs1_ctl", 32'(ctl), 32'(CTL_LU));
        tick(); clr(); #1;
        chk("lu_release", 32'(ctl), 32'(CTL_RUN));
        chk("lu_stall_cnt", stall_cnt_o, 1);

        // x0 never hazards
        EX_mem_read_i = 1'b1; EX_reg_rd_i = 5'd0; ID_reg_rs1_i = 5'd0; #1;
        chk("lu_x0_ctl", 32'(ctl), 32'(CTL_RUN));
        tick(); clr(); #1;
        chk("lu_x0_stall", stall_cnt_o, 1);

        // load-use on rs2
        EX_mem_read_i = 1'b1; EX_reg_rd_i = 5'd7; ID_reg_rs1_i = 5'd3; ID_reg_rs2_i = 5'd7; #1;
        chk("lu_rs2_ctl", 32'(ctl), 32'(CTL_LU));
        tick(); clr(); #1;
        chk("lu_rs2_stall", stall_cnt_o, 2);

        // redirect overrides simultaneous load-use
        EX_redirect_i = 1'b1; EX_mem_read_i = 1'b1; EX_reg_rd_i = 5'd5; ID_reg_rs1_i = 5'd5; #1;
        chk("red_lu_ctl", 32'(ctl), 32'(CTL_RED));
        tick(); clr(); #1;
        chk("red_flush_cnt", flush_cnt_o, 1);
        chk("red_stall_cnt", stall_cnt_o, 2);

        // MDU op with done 33 cycles after the start cycle
        EX_mdu_start_i = 1'b1; #1;
        chk("mdu_start_ctl", 32'(ctl), 32'(CTL_MDU));
        stalls = 1;
        tick(); clr(); #1;
        for (int i = 1; i < 33; i++) begin
            if (ctl == CTL_MDU) stalls++;
            tick();
        end
        chk("mdu_stall_cycles", stalls, 33);
        mdu_done_i = 1'b1; #1;
        chk("mdu_done_ctl", 32'(ctl), 32'(CTL_RUN));
        tick(); clr(); #1;
        chk("mdu_after_ctl", 32'(ctl), 32'(CTL_RUN));
        chk("mdu_stall_cnt", stall_cnt_o, 35);
        chk("mdu_err_clear", 32'(mdu_err_o), 0);

        // memory wait nested inside MDU_WAIT at MDU cycle 5
        EX_mdu_start_i = 1'b1; #1;
        tick(); clr(); #1;
        for (int i = 1; i < 5; i++) tick();
        chk("nest_mdu_ctl", 32'(ctl), 32'(CTL_MDU));
        MEM_req_i = 1'b1; dmem_ready_i = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("nest_mem_ctl", 32'(ctl), 32'(CTL_MEM));
            tick();
        end
        MEM_req_i = 1'b0; dmem_ready_i = 1'b1; #1;
        chk("nest_ready_ctl", 32'(ctl), 32'(CTL_MDU));
        tick(); #1;
        chk("nest_back_mdu", 32'(ctl), 32'(CTL_MDU));
        tick();
        mdu_done_i = 1'b1; #1;
        chk("nest_done_ctl", 32'(ctl), 32'(CTL_RUN));
        tick(); clr(); #1;
        chk("nest_run_ctl", 32'(ctl), 32'(CTL_RUN));
        chk("nest_stall_cnt", stall_cnt_o, 45);

        // watchdog: done never arrives, 40 MDU_WAIT cycles then forced release
        EX_mdu_start_i = 1'b1; #1;
        tick(); clr(); #1;
        for (int i = 1; i < 40; i++) tick();
        chk("wd_last_ctl", 32'(ctl), 32'(CTL_RUN));
        chk("wd_err_before", 32'(mdu_err_o), 0);
        tick();
        chk("wd_err_set", 32'(mdu_err_o), 1);
        chk("wd_run_ctl", 32'(ctl), 32'(CTL_RUN));
        chk("wd_stall_cnt", stall_cnt_o, 85);
        tick(); tick(); tick();
        chk("wd_err_sticky", 32'(mdu_err_o), 1);

        // memory wait from RUN, then reset in the middle of it
        MEM_req_i = 1'b1; dmem_ready_i = 1'b0; #1;
        chk("mem_run_ctl", 32'(ctl), 32'(CTL_MEM));
        tick(); MEM_req_i = 1'b0; #1;
        chk("mem_wait_ctl", 32'(ctl), 32'(CTL_MEM));
        tick();
        chk("mem_stall_cnt", stall_cnt_o, 87);
        rstn = 1'b0; #1;
        chk("rst_forced_ctl", 32'(ctl), 32'(CTL_RUN));
        tick(); rstn = 1'b1; clr(); #1;
        chk("rst_run_ctl", 32'(ctl), 32'(CTL_RUN));
        chk("rst_stall_zero", stall_cnt_o, 0);
        chk("rst_flush_zero", flush_cnt_o, 0);
        chk("rst_err_zero", 32'(mdu_err_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
